// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_grant_t : which cache owns (or last owned) the memory port
package cache_arbiter_pkg;

  localparam int DEF_LINE_WIDTH  = 256;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  typedef enum logic {
    grant_i = 1'b0,
    grant_d = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_reg.sv
// Width-parameterised load-enable register, cleared by async reset.
//   clk, rst (async, active low), en (load), d (next value), q (held value)
module cache_arbiter_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between I-cache and D-cache line requests onto one
// physical-memory port. The winning request is latched, driven to memory
// until pmem_resp, and the returned line is handed back with a one-cycle
// resp pulse to the winner only.
//   i_pmem_*      : I-cache side (read only)
//   d_pmem_*      : D-cache side (read or writeback)
//   pmem_*        : shared memory port; strobes/address/wdata are registered
//   clk, rst      : clock, async active-low reset
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state, state_nxt;
  arb_grant_t last_grant, grant_sel;
  logic       grant_vld;
  logic       i_pend, d_pend;

  logic [ADDR_WIDTH-1:0]      addr_d, addr_q;
  logic                       op_wr_d, op_wr_q;
  logic [1:0]                 line_en;
  logic [1:0][LINE_WIDTH-1:0] line_q;   // [0]=I-cache, [1]=D-cache

  assign i_pend = i_pmem_read;
  assign d_pend = d_pmem_read | d_pmem_write;

  // State register and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= grant_i;
    end else begin
      state <= state_nxt;
      if (grant_vld) last_grant <= grant_sel;
    end
  end

  // Next-state / arbitration; grants only happen from IDLE
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = grant_i;
    case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
          grant_vld = 1'b1;
          grant_sel = (last_grant == grant_i) ? grant_d : grant_i;
        end else if (i_pend) begin
          grant_vld = 1'b1;
          grant_sel = grant_i;
        end else if (d_pend) begin
          grant_vld = 1'b1;
          grant_sel = grant_d;
        end
        if (grant_vld) state_nxt = (grant_sel == grant_d) ? SERVE_D : SERVE_I;
      end
      SERVE_I: if (pmem_resp) state_nxt = RESP_I;
      SERVE_D: if (pmem_resp) state_nxt = RESP_D;
      RESP_I, RESP_D: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state
  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      SERVE_I, SERVE_D: begin
        pmem_read  = ~op_wr_q;
        pmem_write =  op_wr_q;
      end
      RESP_I:  i_pmem_resp = 1'b1;
      RESP_D:  d_pmem_resp = 1'b1;
      default: ;
    endcase
  end

  // Request latch: address is line-aligned on the way in. A D request with
  // both read and write set is treated as a write.
  assign addr_d  = (grant_sel == grant_d)
                 ? {d_pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}}
                 : {i_pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign op_wr_d = (grant_sel == grant_d) & d_pmem_write;

  cache_arbiter_reg #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk(clk), .rst(rst), .en(grant_vld), .d(addr_d), .q(addr_q)
  );

  cache_arbiter_reg #(.WIDTH(1)) u_op (
    .clk(clk), .rst(rst), .en(grant_vld), .d(op_wr_d), .q(op_wr_q)
  );

  cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_wdata (
    .clk(clk), .rst(rst), .en(grant_vld && (grant_sel == grant_d)),
    .d(d_pmem_wdata), .q(pmem_wdata)
  );

  // One line buffer per cache so the idle side's rdata holds its last line.
  // pmem_resp outside SERVE_x never loads a buffer.
  assign line_en[0] = (state == SERVE_I) & pmem_resp;
  assign line_en[1] = (state == SERVE_D) & pmem_resp;

  for (genvar g = 0; g < 2; g++) begin : g_line
    cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_line (
      .clk(clk), .rst(rst), .en(line_en[g]), .d(pmem_rdata), .q(line_q[g])
    );
  end

  assign pmem_address = addr_q;
  assign i_pmem_rdata = line_q[0];
  assign d_pmem_rdata = line_q[1];

  // D-cache must never ask for read and write in the same request
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst)
                 !(d_pmem_read && d_pmem_write))
    else $error("cache_arbiter: d_pmem_read and d_pmem_write both high");

endmodule
